log2_fx: RTL and testbench

LOG2_FX -- requirements
Module: log2_fx

---
 rtl/log2_fx_pkg.sv | 18 +
 rtl/log2_lod.sv | 20 ++
 rtl/log2_fx.sv | 112 +++++++++++
 tb/tb_log2_fx.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/log2_fx_pkg.sv
// Shared types and width helpers for the iterative fixed-point log2 unit.
package log2_fx_pkg;

    typedef enum logic [1:0] {StIdle, StNorm, StIter, StDone} state_t;

    // Integer-part width: covers -F_IN .. W_IN-1-F_IN plus a sign bit.
    function automatic int unsigned i_out_w(input int unsigned w_in, input int unsigned f_in);
        int unsigned span;
        span = (f_in + 1 > w_in - f_in) ? f_in + 1 : w_in - f_in;
        return $clog2(span) + 1;
    endfunction

    function automatic int unsigned w_out_w(input int unsigned w_in, input int unsigned f_in,
                                            input int unsigned f_out);
        return i_out_w(w_in, f_in) + f_out;
    endfunction

endpackage

// File: rtl/log2_lod.sv
// Combinational leading-one detector: position of the highest set bit plus an all-zero flag.
module log2_lod #(
    parameter int unsigned W_IN = 16,
    localparam int unsigned PW = (W_IN > 1) ? $clog2(W_IN) : 1
) (
    input  logic [W_IN-1:0] val,
    output logic [PW-1:0]   pos,
    output logic            zero
);

    always_comb begin
        pos = '0;
        for (int i = 0; i < W_IN; i++) begin
            if (val[i]) pos = PW'(i);
        end
    end

    assign zero = ~|val;

endmodule

// File: rtl/log2_fx.sv
// Iterative log2 of an unsigned fixed-point operand: normalise once, then one result
// fraction bit per cycle by repeated squaring of the mantissa.
module log2_fx
    import log2_fx_pkg::*;
#(
    parameter int unsigned W_IN  = 16,
    parameter int unsigned F_IN  = 13,
    parameter int unsigned F_OUT = 8,
    localparam int unsigned I_OUT = i_out_w(W_IN, F_IN),
    localparam int unsigned W_OUT = w_out_w(W_IN, F_IN, F_OUT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  v_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_OUT-1:0] v_out,
    output logic             out_zero
);

    localparam int unsigned PW = (W_IN > 1) ? $clog2(W_IN) : 1;
    localparam int unsigned CW = (F_OUT > 1) ? $clog2(F_OUT) : 1;
    localparam logic [W_OUT-1:0] MinVal = {1'b1, {(W_OUT-1){1'b0}}};

    state_t           state_q;
    logic [W_IN-1:0]  op_q;
    logic [W_IN-1:0]  m_q;
    logic [I_OUT-1:0] int_q;
    logic [F_OUT-1:0] frac_q;
    logic [CW-1:0]    cnt_q;
    logic             zero_q;

    logic [PW-1:0]    lead_pos;
    logic             op_zero;
    logic [I_OUT-1:0] int_norm;
    logic [W_IN-1:0]  m_norm;
    logic [W_IN:0]    sq_hi;
    logic [W_IN-2:0]  sq_unused;
    logic             sq_ge2;
    logic [W_IN-1:0]  m_next;
    logic [F_OUT-1:0] frac_next;

    log2_lod #(
        .W_IN(W_IN)
    ) u_lod (
        .val (op_q),
        .pos (lead_pos),
        .zero(op_zero)
    );

    // Modular subtraction is exact because p - F_IN always fits in I_OUT signed bits.
    assign int_norm = I_OUT'(lead_pos) - I_OUT'(F_IN);
    assign m_norm   = op_q << (PW'(W_IN - 1) - lead_pos);

    // Single shared squarer; the low product bits fall below the mantissa precision.
    assign {sq_hi, sq_unused} = {{W_IN{1'b0}}, m_q} * {{W_IN{1'b0}}, m_q};
    assign sq_ge2    = sq_hi[W_IN];
    assign m_next    = sq_ge2 ? sq_hi[W_IN:1] : sq_hi[W_IN-1:0];
    assign frac_next = (frac_q << 1) | F_OUT'(sq_ge2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            v_out     <= '0;
            out_zero  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        op_q     <= v_in;
                        in_ready <= 1'b0;
                        state_q  <= StNorm;
                    end
                end
                StNorm: begin
                    m_q     <= m_norm;
                    int_q   <= int_norm;
                    zero_q  <= op_zero;
                    frac_q  <= '0;
                    cnt_q   <= '0;
                    state_q <= StIter;
                end
                StIter: begin
                    m_q    <= m_next;
                    frac_q <= frac_next;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(F_OUT - 1)) begin
                        state_q   <= StDone;
                        out_valid <= 1'b1;
                        out_zero  <= zero_q;
                        v_out     <= zero_q ? MinVal : {int_q, frac_next};
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_log2_fx.sv
// Self-checking bench for log2_fx: directed vectors, random operands against a bit-level model,
// back-pressure, and mid-iteration reset.
module tb_log2_fx;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] v_in;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] v_out;
    logic        out_zero;

    typedef struct {
        int val;
        bit zero;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    log2_fx #(
        .W_IN (16),
        .F_IN (13),
        .F_OUT(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .v_in     (v_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .v_out    (v_out),
        .out_zero (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: truncating repeated-squaring log2 on a Q3.13 operand, Q5.8 result.
    function automatic int model(input logic [15:0] v);
        int     p;
        int     frac;
        longint m;
        longint sq;
        if (v == 16'h0000) return -4096;
        p = 0;
        for (int i = 0; i < 16; i++) if (v[i]) p = i;
        m = longint'(v) << (15 - p);
        frac = 0;
        for (int k = 0; k < 8; k++) begin
            sq = m * m;
            if (sq >= (longint'(1) << 31)) begin
                frac = frac * 2 + 1;
                m = sq >>> 16;
            end else begin
                frac = frac * 2;
                m = sq >>> 15;
            end
        end
        return (p - 13) * 256 + frac;
    endfunction

    task automatic do_op(input logic [15:0] v, input int ev, input bit ez, input int hold);
        int   n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        v_in = v;
        sb.push_back('{val: ev, zero: ez});
        @(posedge clk); #1;
        // Garbage on the input side while busy must be ignored.
        in_valid = 1'($urandom);
        v_in = 16'($urandom);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 30);
        check_eq("latency", n, 9);
        e = sb.pop_front();
        check_eq("v_out", $signed(v_out), e.val);
        check_eq("out_zero", out_zero, e.zero);
        repeat (hold) begin
            @(posedge clk); #1;
            check_eq("hold_v_out", $signed(v_out), e.val);
            check_eq("hold_out_valid", out_valid, 1);
            check_eq("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        check_eq("in_ready_in_done", in_ready, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("out_valid_after_hs", out_valid, 0);
        check_eq("in_ready_after_hs", in_ready, 1);
    endtask

    initial begin
        logic [15:0] rv;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        v_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_v_out", v_out, 0);
        check_eq("rst_out_zero", out_zero, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("in_ready_after_release", in_ready, 1);

        do_op(16'h2000, 0, 1'b0, 0);
        do_op(16'h4000, 256, 1'b0, 5);
        do_op(16'h0001, -3328, 1'b0, 0);
        do_op(16'h6000, 405, 1'b0, 1);
        do_op(16'hFFFF, 767, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            rv = 16'($urandom);
            do_op(rv, model(rv), rv == 16'h0000, int'($urandom_range(0, 2)));
        end
        do_op(16'h0000, -4096, 1'b1, 2);

        // Reset during the 4th iteration cycle must abort the operation.
        in_valid = 1'b1;
        v_in = 16'h2000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst_in_ready", in_ready, 0);
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_v_out", v_out, 0);
        check_eq("midrst_out_zero", out_zero, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("midrst_idle", in_ready, 1);
        repeat (12) @(posedge clk);
        #1;
        check_eq("midrst_no_stale_result", out_valid, 0);
        do_op(16'h4000, 256, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
